// File: rtl/ion_pkg.sv
// Shared encodings for the ion CPU data-port blocks.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package ion_pkg;

  // Transfer type on the CPU data port
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  // Transfer size
  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  // Response
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // DTCM controller state: names the data phase currently on the bus
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RD_WAIT,
    ERR1,
    ERR2
  } dtcm_state_t;

  // Address-phase attributes kept for the following data phase
  typedef struct packed {
    logic [1:0] lane;
    logic [2:0] size;
  } dtcm_aph_t;

  // Byte-lane write enables for a little-endian access
  function automatic logic [3:0] lane_en(input logic [1:0] lane, input logic [2:0] size);
    case (size)
      SIZE_BYTE: return 4'b0001 << lane;
      SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  // Natural alignment check; illegal size codes are never aligned
  function automatic logic aligned(input logic [1:0] lane, input logic [2:0] size);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~lane[0];
      SIZE_WORD: return (lane == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dtcm_ram.sv
// Single-port DTCM storage with byte write enables and registered read.
// Latency: write commits at the clock edge; read data valid one cycle after en with we==0.
// Backpressure: none; the controller owns port arbitration.
// Ports: CLK clock; en port enable; we[3:0] byte-lane writes; addr word index;
//        wdata write data; rdata registered read data (holds when not reading).
module dtcm_ram
  import ion_pkg::*;
#(
  parameter int NUM_WORDS = 1024,
  parameter int AW        = $clog2(NUM_WORDS)
) (
  input  logic          CLK,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [NUM_WORDS];

  // No reset: contents survive reset and the array maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      if (we == 4'b0000) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dtcm_ctrl.sv
// Data TCM controller: zero-wait CPU data-port slave in front of a single-port RAM.
// Latency: reads/writes zero wait; a read right after a write costs one wait; errors take two cycles.
// Backpressure: DREADY_O low in RD_WAIT and ERR1; no address phase is accepted then.
// Ports: CLK, RESET_NI (async, active-low); DADDR_I/DTRANS_I/DSIZE_I/DWRITE_I address phase;
//        DWDATA_I write data phase; DRDATA_O/DREADY_O/DRESP_O data-phase response.
module dtcm_ctrl
  import ion_pkg::*;
#(
  parameter int unsigned OPTION_DTCM_NUM_WORDS = 1024,
  parameter logic [31:0] OPTION_DTCM_BASE      = 32'h0001_0000
) (
  input  logic        CLK,
  input  logic        RESET_NI,
  input  logic [31:0] DADDR_I,
  input  logic [1:0]  DTRANS_I,
  input  logic [2:0]  DSIZE_I,
  input  logic        DWRITE_I,
  input  logic [31:0] DWDATA_I,
  output logic [31:0] DRDATA_O,
  output logic        DREADY_O,
  output logic [1:0]  DRESP_O
);

  localparam int          AW        = $clog2(OPTION_DTCM_NUM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(4 * OPTION_DTCM_NUM_WORDS);

  dtcm_state_t   state_q, state_d;
  dtcm_aph_t     aph_q;
  logic [AW-1:0] word_q;
  logic [31:0]   rdata_q;

  logic [31:0]   offset;
  logic          aphase_vld;
  logic          legal;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  // Window test on the base-relative offset: addresses below BASE wrap to
  // huge offsets and fail the same unsigned compare. BASE is window-aligned,
  // so offset[1:0] equals the byte lane of the address.
  assign offset     = DADDR_I - OPTION_DTCM_BASE;
  assign aphase_vld = DREADY_O && (DTRANS_I == TRANS_NONSEQ || DTRANS_I == TRANS_SEQ);
  assign legal      = (offset < WIN_BYTES) && aligned(offset[1:0], DSIZE_I);

  assign DREADY_O = !(state_q == RD_WAIT || state_q == ERR1);
  assign DRESP_O  = (state_q == ERR1 || state_q == ERR2) ? RESP_ERROR : RESP_OKAY;
  // Live RAM data during RD, otherwise the word captured at the end of the last RD.
  assign DRDATA_O = (state_q == RD) ? ram_rdata : rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_WAIT: state_d = RD;
      ERR1:    state_d = ERR2;
      default: begin
        if (!aphase_vld) begin
          state_d = IDLE;
        end else if (!legal) begin
          state_d = ERR1;
        end else if (DWRITE_I) begin
          state_d = WR;
        end else if (state_q == WR) begin
          // RAM port is busy with the write this cycle; read next cycle instead.
          state_d = RD_WAIT;
        end else begin
          state_d = RD;
        end
      end
    endcase
  end

  // RAM port: the WR data phase owns it, then a deferred read, then a fresh read.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 4'b0000;
    ram_addr = offset[AW+1:2];
    if (state_q == WR) begin
      ram_en   = 1'b1;
      ram_we   = lane_en(aph_q.lane, aph_q.size);
      ram_addr = word_q;
    end else if (state_q == RD_WAIT) begin
      ram_en   = 1'b1;
      ram_addr = word_q;
    end else if (aphase_vld && legal && !DWRITE_I) begin
      ram_en   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_NI) begin
    if (!RESET_NI) begin
      state_q <= IDLE;
      word_q  <= '0;
      aph_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (aphase_vld) begin
        word_q <= offset[AW+1:2];
        aph_q  <= '{lane: offset[1:0], size: DSIZE_I};
      end
      if (state_q == RD) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  dtcm_ram #(
    .NUM_WORDS (OPTION_DTCM_NUM_WORDS),
    .AW        (AW)
  ) u_ram (
    .CLK   (CLK),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (DWDATA_I),
    .rdata (ram_rdata)
  );

endmodule
